// File: rtl/add_share_pkg.sv
// Shared types and helpers for the shared-adder arbiter: FSM states, default width,
// and the round-robin pick function.
package add_share_pkg;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  localparam int unsigned ADD_WIDTH = 16;
  localparam int unsigned MAX_REQ   = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid at or above ptr, wrapping modulo nreq (nreq <= MAX_REQ).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int unsigned        nreq);
    pick_t       res;
    int unsigned j;
    res = '0;
    // Walk the search order backwards so the earliest candidate wins.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      j = {29'd0, ptr} + unsigned'(k);
      if (j >= nreq) j = j - nreq;
      if ((unsigned'(k) < nreq) && valid[j[2:0]]) begin
        res.found = 1'b1;
        res.idx   = j[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/add_share_arbiter_adder_core.sv
// Combinational WIDTH-bit Kogge-Stone adder with carry-in; also exposes the carry into
// the MSB so the caller can derive signed overflow.
module adder_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    // Fold carry-in into bit 0 so every prefix group carries it along.
    g[0]  = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    g_nxt = g;
    p_nxt = p;
    for (int l = 0; l < int'(LEVELS); l++) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= (1 << l)) begin
          g_nxt[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p_nxt[i] = p[i] & p[i - (1 << l)];
        end
      end
      g = g_nxt;
      p = p_nxt;
    end
  end

  assign sum   = (a ^ b) ^ {g[WIDTH-2:0], cin};
  assign cout  = g[WIDTH-1];
  assign c_msb = g[WIDTH-2];

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ valid/ready requesters; results land
// in a one-entry, backpressure-aware output register tagged with the requester id.
module add_share_arbiter
  import add_share_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = ADD_WIDTH,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic [IDW-1:0]        rsp_id
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         ptr_ext;
  pick_t              pick;
  logic [IDW-1:0]     grant;
  logic               can_accept;
  logic               fire;
  logic [WIDTH-1:0]   sel_a, sel_b, add_sum;
  logic               sel_cin, add_cout, add_c_msb;

  assign rsp_valid = (state_q == ST_FULL);

  always_comb begin
    valid_ext            = '0;
    valid_ext[NREQ-1:0]  = req_valid;
    ptr_ext              = '0;
    ptr_ext[IDW-1:0]     = rr_ptr_q;
    pick                 = rr_pick(valid_ext, ptr_ext, NREQ);
    grant                = pick.idx[IDW-1:0];
    // Draining the held result frees the register for a same-cycle refill.
    can_accept           = (state_q == ST_EMPTY) || rsp_ready;
    fire                 = pick.found && can_accept && !rst;
    req_ready            = '0;
    sel_a                = '0;
    sel_b                = '0;
    sel_cin              = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant == IDW'(i)) begin
        req_ready[i] = fire;
        sel_a        = req_a[i*WIDTH +: WIDTH];
        sel_b        = req_b[i*WIDTH +: WIDTH];
        sel_cin      = req_cin[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      state_d  = ST_FULL;
      rr_ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  adder_core #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (sel_a),
    .b    (sel_b),
    .cin  (sel_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .c_msb(add_c_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_id   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (fire) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_ovf  <= add_c_msb ^ add_cout;
        rsp_id   <= grant;
      end
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: expected results are queued when a grant is
// expected and compared when the result register presents them.
module tb_add_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic [1:0]  rsp_id;

  add_share_arbiter #(
    .NREQ (4),
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .rsp_ovf  (rsp_ovf),
    .rsp_id   (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [19:0] sb[$];
  logic [19:0] last_exp;
  logic [15:0] ta[4];
  logic [15:0] tb_b[4];
  logic        tc[4];

  // {id, cout, ovf, sum}
  function automatic logic [19:0] model(input logic [1:0] id, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + {16'd0, c};
    return {id, t[16], (a[15] == b[15]) && (t[15] != a[15]), t[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
    ta[i]            = a;
    tb_b[i]          = b;
    tc[i]            = c;
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_cin[i]        = c;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) set_ops(i, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic push_exp(input int i);
    sb.push_back(model(2'(i), ta[i], tb_b[i], tc[i]));
  endtask

  function automatic logic [31:0] rsp_vec();
    return {11'd0, rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum};
  endfunction

  task automatic pop_rsp(input string tag);
    logic [19:0] e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=%h expected=<scoreboard entry>", tag, rsp_vec());
    end else begin
      e        = sb.pop_front();
      last_exp = e;
      chk(tag, rsp_vec(), {11'd0, 1'b1, e});
    end
  endtask

  task automatic peek_rsp(input string tag);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=%h expected=<scoreboard entry>", tag, rsp_vec());
    end else begin
      chk(tag, rsp_vec(), {11'd0, 1'b1, sb[0]});
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    last_exp  = '0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    set_ops(0, 16'h1234, 16'h0FFF, 1'b1);
    sample();
    chk("ready_in_reset", {28'd0, req_ready}, 32'h0);
    adv();
    adv();

    // Single request from requester 0 right after reset.
    rst = 1'b0;
    sample();
    chk("reset_state", rsp_vec(), 32'h0);
    chk("ready_single", {28'd0, req_ready}, 32'h1);
    push_exp(0);
    adv();
    req_valid = 4'b0000;
    sample();
    pop_rsp("rsp_single");
    adv();

    // Requester 2: carry out, then signed overflow.
    req_valid = 4'b0100;
    set_ops(2, 16'hFFFF, 16'h0001, 1'b0);
    sample();
    chk("ready_carry", {28'd0, req_ready}, 32'h4);
    push_exp(2);
    adv();
    set_ops(2, 16'h7FFF, 16'h0001, 1'b0);
    sample();
    chk("ready_ovf", {28'd0, req_ready}, 32'h4);
    pop_rsp("rsp_carry");
    push_exp(2);
    adv();
    req_valid = 4'b0000;
    sample();
    pop_rsp("rsp_ovf");
    adv();

    // Pointer sits at 3: 0101 wraps to 0, then skips 1 to reach 2.
    req_valid = 4'b0101;
    rand_ops();
    sample();
    chk("drain_keeps_data", rsp_vec(), {11'd0, 1'b0, last_exp});
    chk("ready_wrap", {28'd0, req_ready}, 32'h1);
    push_exp(0);
    adv();
    rand_ops();
    sample();
    chk("ready_skip", {28'd0, req_ready}, 32'h4);
    pop_rsp("rsp_wrap");
    push_exp(2);
    adv();
    req_valid = 4'b0000;
    sample();
    pop_rsp("rsp_skip");
    adv();

    // All requesting, full throughput: grants 3,0,1,2,3,0.
    req_valid = 4'b1111;
    g = 3;
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      sample();
      chk($sformatf("ready_rr%0d", k), {28'd0, req_ready}, 32'(1 << g));
      if (k > 0) pop_rsp($sformatf("rsp_rr%0d", k));
      push_exp(g);
      adv();
      g = (g + 1) % 4;
    end

    // Backpressure: held result stays put, nobody is granted.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      sample();
      chk($sformatf("ready_bp%0d", k), {28'd0, req_ready}, 32'h0);
      peek_rsp($sformatf("hold_bp%0d", k));
      adv();
    end
    rsp_ready = 1'b1;
    rand_ops();
    sample();
    chk("ready_release", {28'd0, req_ready}, 32'h2);
    pop_rsp("rsp_release");
    push_exp(1);
    adv();
    req_valid = 4'b0000;
    sample();
    chk("ready_idle", {28'd0, req_ready}, 32'h0);
    pop_rsp("rsp_after_bp");
    adv();

    // Reset while holding an undelivered result.
    req_valid = 4'b1000;
    rand_ops();
    sample();
    chk("ready_pre_rst", {28'd0, req_ready}, 32'h8);
    push_exp(3);
    adv();
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    sample();
    chk("ready_mid_rst", {28'd0, req_ready}, 32'h0);
    adv();
    sb.delete();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    rand_ops();
    sample();
    chk("post_rst_state", rsp_vec(), 32'h0);
    chk("ready_post_rst", {28'd0, req_ready}, 32'h1);
    push_exp(0);
    adv();
    req_valid = 4'b0000;
    sample();
    pop_rsp("rsp_post_rst");
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
